// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle between four requesters, one consumer and the
// shared comparator. The requester count is fixed at four.
interface cmp_share_arbiter_if #(
    parameter int W = 4
);
    localparam int N = 4;

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic           resp_gt;
    logic           resp_lt;
    logic           resp_eq;
    logic           busy;
    logic [7:0]     done_cnt;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_gt, resp_lt, resp_eq,
               busy, done_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_gt, resp_lt, resp_eq,
               busy, done_cnt
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// One unsigned magnitude comparator shared by four requesters under
// round-robin arbitration; one transaction in flight at a time.
module cmp_share_arbiter #(
    parameter int W = 4
) (
    input logic               clk,
    input logic               rst,
    cmp_share_arbiter_if.slave bus
);
    localparam int unsigned N = 4;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESP
    } state_t;

    state_t         state_q;
    logic [1:0]     rr_ptr_q;
    logic [1:0]     id_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           gt_q;
    logic           lt_q;
    logic           eq_q;
    logic [7:0]     done_cnt_q;

    logic [1:0]     sel_d;
    logic [1:0]     idx_d;
    logic           found_d;
    logic [N-1:0]   ready_d;

    // First valid requester at or after rr_ptr, wrapping 3 -> 0.
    always_comb begin
        sel_d   = '0;
        idx_d   = '0;
        found_d = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx_d = rr_ptr_q + 2'(k);
            if (!found_d && bus.req_valid[idx_d]) begin
                found_d = 1'b1;
                sel_d   = idx_d;
            end
        end
    end

    always_comb begin
        ready_d = '0;
        if (!rst && state_q == IDLE && found_d) begin
            ready_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        a_q     <= bus.req_a[int'(sel_d)*W +: W];
                        b_q     <= bus.req_b[int'(sel_d)*W +: W];
                        id_q    <= sel_d;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    gt_q    <= (a_q > b_q);
                    lt_q    <= (a_q < b_q);
                    eq_q    <= (a_q == b_q);
                    state_q <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        rr_ptr_q <= id_q + 2'd1;
                        if (done_cnt_q != '1) begin
                            done_cnt_q <= done_cnt_q + 8'd1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Status outputs are masked while rst is high, ahead of the reset edge.
    assign bus.req_ready  = ready_d;
    assign bus.resp_valid = !rst && (state_q == RESP);
    assign bus.busy       = !rst && (state_q != IDLE);
    assign bus.resp_id    = id_q;
    assign bus.resp_gt    = gt_q;
    assign bus.resp_lt    = lt_q;
    assign bus.resp_eq    = eq_q;
    assign bus.done_cnt   = done_cnt_q;
endmodule
